// File: rtl/div_count_calc_pkg.sv
// Shared types and constants for the divider-count calculator.
// DIV_COUNT_CALC_ROUND_EN widens the dividend by one bit for round-to-nearest.
package div_count_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef DIV_COUNT_CALC_ROUND_EN
    // CLK_FREQ_HZ + req_freq can carry into bit 32.
    localparam int DIVIDEND_W = 33;
    localparam int DIV_ITERS  = 33;
`else
    localparam int DIVIDEND_W = 32;
    localparam int DIV_ITERS  = 32;
`endif

endpackage

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, ITERS cycles per start.
// done_o is high during the cycle whose closing edge performs the final iteration.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 33,
    parameter int ITERS      = DIVIDEND_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o,
    output logic [DIVISOR_W-1:0]  remainder_o
);

    localparam int CW = $clog2(ITERS + 1);

    logic                  running_q;
    logic [CW-1:0]         cnt_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  dvs_q;

    logic [DIVISOR_W:0]    rem_shift;
    logic [DIVISOR_W-1:0]  rem_sub;
    logic                  fits;

    // The remainder stays below the divisor, so the low bits of the subtraction are exact.
    always_comb begin
        rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        rem_sub   = rem_shift[DIVISOR_W-1:0] - dvs_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= CW'(ITERS);
            rem_q     <= '0;
            quo_q     <= dividend_i;
            dvs_q     <= divisor_i;
        end else if (running_q) begin
            rem_q <= fits ? rem_sub : rem_shift[DIVISOR_W-1:0];
            quo_q <= {quo_q[DIVIDEND_W-2:0], fits};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done_o      = running_q && (cnt_q == CW'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/div_count_calc.sv
// Converts a requested output frequency into the clock divider's toggle count.
// Define DIV_COUNT_CALC_ROUND_EN for round-to-nearest instead of truncation.
module div_count_calc
    import div_count_calc_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int          FREQ_W        = 32,
    parameter int          CNT_W         = 32,
    parameter int unsigned DEFAULT_COUNT = 2
) (
    input  logic              inclk,
    input  logic              reset,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_freq is sampled only on that edge and the requester may change it afterwards.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FREQ_W-1:0] req_freq,
    output logic [CNT_W-1:0]  div_count,
    output logic              div_count_valid,
    output logic              busy,
    output logic              err_out,
    output state_t            state_o
);

    localparam int DVS_W = FREQ_W + 1;
    localparam int QW    = (DIVIDEND_W > CNT_W) ? DIVIDEND_W : CNT_W;
    localparam int QW1   = QW + 1;

    state_t                state_q;
    logic [CNT_W-1:0]      div_count_q;
    logic                  valid_q;
    logic                  err_q;
    logic                  busy_q;
    logic                  ready_q;
    logic                  zero_q;

    logic                  accept;
    logic                  div_start;
    logic                  div_done;
    logic [DVS_W-1:0]      divisor_d;
    logic [DIVIDEND_W-1:0] dividend_d;
    logic [DIVIDEND_W-1:0] div_quo;
    logic [DVS_W-1:0]      div_rem_unused;

    logic [QW1-1:0]        quo_w;
    logic [CNT_W-1:0]      res_count_d;
    logic                  res_err_d;

    assign accept    = req_valid && ready_q;
    assign div_start = accept && (req_freq != '0);
    assign divisor_d = {req_freq, 1'b0};

`ifdef DIV_COUNT_CALC_ROUND_EN
    assign dividend_d = DIVIDEND_W'(CLK_FREQ_HZ) + DIVIDEND_W'(req_freq);
`else
    assign dividend_d = DIVIDEND_W'(CLK_FREQ_HZ);
`endif

    seq_restoring_divider #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DVS_W),
        .ITERS      (DIV_ITERS)
    ) u_div (
        .clk_i       (inclk),
        .rst_i       (reset),
        .start_i     (div_start),
        .dividend_i  (dividend_d),
        .divisor_i   (divisor_d),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem_unused)
    );

    // A zero quotient means outclk cannot be that fast; the fastest legal count is 1.
    always_comb begin
        quo_w       = QW1'(div_quo);
        res_count_d = CNT_W'(quo_w);
        res_err_d   = 1'b0;
        if (quo_w == '0) begin
            res_count_d = CNT_W'(1);
            res_err_d   = 1'b1;
        end else if (quo_w > QW1'({CNT_W{1'b1}})) begin
            res_count_d = '1;
            res_err_d   = 1'b1;
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_count_q <= CNT_W'(DEFAULT_COUNT);
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (req_freq == '0) begin
                            zero_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            zero_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= DIV;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    if (zero_q) begin
                        err_q <= 1'b1;
                    end else begin
                        div_count_q <= res_count_d;
                        valid_q     <= 1'b1;
                        err_q       <= res_err_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = ready_q;
    assign div_count       = div_count_q;
    assign div_count_valid = valid_q;
    assign err_out         = err_q;
    assign busy            = busy_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_div_count_calc.sv
// Directed bench for div_count_calc: timing of busy/strobes, clamp rules,
// back-to-back requests and reset during a division.
module tb_div_count_calc;
    import div_count_calc_pkg::*;

    logic        inclk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_freq;
    logic [31:0] div_count;
    logic        div_count_valid;
    logic        busy;
    logic        err_out;
    state_t      state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 inclk = ~inclk;

    div_count_calc dut (
        .inclk           (inclk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_freq        (req_freq),
        .div_count       (div_count),
        .div_count_valid (div_count_valid),
        .busy            (busy),
        .err_out         (err_out),
        .state_o         (state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    // Issue one request and follow it cycle by cycle to its DONE edge.
    task automatic run_req(input string tag, input logic [31:0] freq,
                           input logic [31:0] exp_cnt, input logic exp_v, input logic exp_e);
        int waited;
        int lat;
        int bad_busy;
        int early;
        waited   = 0;
        bad_busy = 0;
        early    = 0;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_freq  = freq;
        tick();
        req_valid = 1'b0;
        req_freq  = $urandom;
        lat = (freq == 0) ? 1 : DIV_ITERS + 1;
        for (int i = 0; i < lat; i++) begin
            if (busy !== ((freq != 0) && (i < lat - 1))) bad_busy++;
            if (div_count_valid || err_out) early++;
            tick();
        end
        check({tag, "_busy_prof"}, bad_busy, 0);
        check({tag, "_early_strobe"}, early, 0);
        check({tag, "_count"}, div_count, exp_cnt);
        check({tag, "_valid"}, div_count_valid, exp_v);
        check({tag, "_err"}, err_out, exp_e);
        tick();
        check({tag, "_strobes_1cyc"}, {div_count_valid, err_out}, 0);
        check({tag, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int cyc;
        int stray;
        int accepted;
        int pulse_cyc[2];

        reset     = 1'b1;
        req_valid = 1'b0;
        req_freq  = '0;
        repeat (3) tick();
        check("rst_count", div_count, 2);
        check("rst_strobes", {div_count_valid, err_out, busy}, 0);
        check("rst_ready", req_ready, 0);
        check("rst_state", state_o, IDLE);
        reset = 1'b0;
        tick();
        check("idle_ready", req_ready, 1);
        check("idle_count", div_count, 2);

        run_req("f1000", 32'd1000, 32'd25000, 1'b1, 1'b0);
        run_req("f25M", 32'd25_000_000, 32'd1, 1'b1, 1'b0);
`ifdef DIV_COUNT_CALC_ROUND_EN
        run_req("too_fast", 32'd60_000_000, 32'd1, 1'b1, 1'b1);
`else
        run_req("too_fast", 32'd30_000_000, 32'd1, 1'b1, 1'b1);
`endif
        run_req("zero", 32'd0, 32'd1, 1'b0, 1'b1);
`ifdef DIV_COUNT_CALC_ROUND_EN
        run_req("f7", 32'd7, 32'd3571429, 1'b1, 1'b0);
`else
        run_req("f7", 32'd7, 32'd3571428, 1'b1, 1'b0);
`endif

        // req_valid held high across two requests.
        exp_q.push_back(32'd25000);
        exp_q.push_back(32'd12500);
        pulses   = 0;
        cyc      = 0;
        accepted = 0;
        pulse_cyc[0] = 0;
        pulse_cyc[1] = 0;
        req_valid = 1'b1;
        req_freq  = 32'd1000;
        while (pulses < 2 && cyc < 200) begin
            tick();
            cyc++;
            if (accepted == 0 && busy) begin
                accepted = 1;
                req_freq = 32'd2000;
            end
            if (div_count_valid) begin
                check("b2b_value", div_count, exp_q.pop_front());
                pulse_cyc[pulses] = cyc;
                pulses++;
                if (pulses == 2) req_valid = 1'b0;
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], DIV_ITERS + 2);
        stray = 0;
        repeat (5) begin
            tick();
            if (div_count_valid || err_out || busy) stray++;
        end
        check("b2b_no_third", stray, 0);

        // Reset sampled on the tenth edge of a division.
        while (!req_ready) tick();
        req_valid = 1'b1;
        req_freq  = 32'd1000;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        check("midrst_count", div_count, 2);
        check("midrst_state", state_o, IDLE);
        check("midrst_sig", {div_count_valid, err_out, busy, req_ready}, 0);
        reset = 1'b0;
        stray = 0;
        repeat (40) begin
            tick();
            if (div_count_valid || err_out || busy) stray++;
        end
        check("midrst_no_strobe", stray, 0);
        run_req("after_rst", 32'd1000, 32'd25000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
